// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter_if
//  Description : Requester-side bus of the SRAM arbiter. Flat per-port
//                vectors; port i owns bit i / slice [32*i +: 32] etc.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]    req;
    logic [NUM_PORTS-1:0]    we;
    logic [4*NUM_PORTS-1:0]  be;
    logic [32*NUM_PORTS-1:0] addr;
    logic [32*NUM_PORTS-1:0] wdata;
    logic [NUM_PORTS-1:0]    ack;
    logic                    ack_err;
    logic [31:0]             rdata;

    // Requesters drive the request side and observe the completion.
    modport master (
        output req, we, be, addr, wdata,
        input  ack, ack_err, rdata
    );

    // The arbiter consumes requests and produces the completion.
    modport slave (
        input  req, we, be, addr, wdata,
        output ack, ack_err, rdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : N-port arbiter onto the BaseRAM / ExtRAM asynchronous SRAMs.
//                Fixed-priority or round-robin grant, WAIT_CYCLES per access,
//                byte enables, error reply for unmapped addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int WAIT_CYCLES = 2,
    parameter int RR_MODE     = 0
) (
    input  logic          clk,
    input  logic          reset,
    sram_arbiter_if.slave bus,

    output logic [19:0]   base_ram_addr,
    output logic [3:0]    base_ram_be_n,
    output logic          base_ram_ce_n,
    output logic          base_ram_oe_n,
    output logic          base_ram_we_n,
    output logic [31:0]   base_ram_wdata,
    output logic          base_ram_data_oe,
    input  logic [31:0]   base_ram_rdata,

    output logic [19:0]   ext_ram_addr,
    output logic [3:0]    ext_ram_be_n,
    output logic          ext_ram_ce_n,
    output logic          ext_ram_oe_n,
    output logic          ext_ram_we_n,
    output logic [31:0]   ext_ram_wdata,
    output logic          ext_ram_data_oe,
    input  logic [31:0]   ext_ram_rdata
);

    localparam int c_IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_CNT_W = $clog2(WAIT_CYCLES);
    localparam logic [c_CNT_W-1:0]   c_CNT_INIT = c_CNT_W'(WAIT_CYCLES - 1);
    localparam logic [c_IDX_W-1:0]   c_PTR_INIT = c_IDX_W'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0] c_ACK_ONE  = NUM_PORTS'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic                 r_we;
    logic [3:0]           r_be;
    logic [19:0]          r_ram_addr;
    logic                 r_bank;      // 0 = BaseRAM, 1 = ExtRAM
    logic [31:0]          r_wdata;
    logic                 r_err;
    logic [31:0]          r_rdata;

    // Winner of the current arbitration round and its request fields.
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_win;
    logic                 w_win_we;
    logic [3:0]           w_win_be;
    logic [29:0]          w_win_addr;  // byte address bits [31:2]
    logic [31:0]          w_win_wdata;
    logic                 w_mapped;

    // Pick the winner: the first pass only accepts ports above the RR pointer
    // (every port in fixed mode), the second pass wraps around from port 0.
    always_comb begin
        w_found     = 1'b0;
        w_win       = '0;
        w_win_we    = 1'b0;
        w_win_be    = '0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_found && bus.req[i] && (RR_MODE == 0 || i > int'(r_rr_ptr))) begin
                w_found     = 1'b1;
                w_win       = c_IDX_W'(i);
                w_win_we    = bus.we[i];
                w_win_be    = bus.be[4*i +: 4];
                w_win_addr  = bus.addr[32*i+2 +: 30];
                w_win_wdata = bus.wdata[32*i +: 32];
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_found && bus.req[i]) begin
                w_found     = 1'b1;
                w_win       = c_IDX_W'(i);
                w_win_we    = bus.we[i];
                w_win_be    = bus.be[4*i +: 4];
                w_win_addr  = bus.addr[32*i+2 +: 30];
                w_win_wdata = bus.wdata[32*i +: 32];
            end
        end
        w_mapped = (w_win_addr[29:21] == 9'h100);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transaction latch, wait counter, read capture and RR pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rr_ptr   <= c_PTR_INIT;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_ram_addr <= '0;
            r_bank     <= 1'b0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx      <= w_win;
                        r_we       <= w_win_we;
                        r_be       <= w_win_be;
                        r_ram_addr <= w_win_addr[19:0];
                        r_bank     <= w_win_addr[20];
                        r_wdata    <= w_win_wdata;
                        r_err      <= !w_mapped;
                        r_rdata    <= '0;
                        r_cnt      <= c_CNT_INIT;
                        if (RR_MODE != 0) begin
                            r_rr_ptr <= w_win;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end else if (!r_we) begin
                        // Last access cycle: the SRAM output has settled.
                        r_rdata <= r_bank ? ext_ram_rdata : base_ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state plus SRAM strobes and requester completion.
    always_comb begin
        w_state_nxt      = r_state;
        base_ram_addr    = '0;
        base_ram_be_n    = 4'hF;
        base_ram_ce_n    = 1'b1;
        base_ram_oe_n    = 1'b1;
        base_ram_we_n    = 1'b1;
        base_ram_wdata   = '0;
        base_ram_data_oe = 1'b0;
        ext_ram_addr     = '0;
        ext_ram_be_n     = 4'hF;
        ext_ram_ce_n     = 1'b1;
        ext_ram_oe_n     = 1'b1;
        ext_ram_we_n     = 1'b1;
        ext_ram_wdata    = '0;
        ext_ram_data_oe  = 1'b0;
        bus.ack          = '0;
        bus.ack_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = w_mapped ? S_ACCESS : S_DONE;
                end
            end
            S_ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
                // we_n rises on the final cycle so data is held past the strobe.
                if (!r_bank) begin
                    base_ram_ce_n = 1'b0;
                    base_ram_addr = r_ram_addr;
                    if (r_we) begin
                        base_ram_be_n    = ~r_be;
                        base_ram_we_n    = (r_cnt == '0);
                        base_ram_wdata   = r_wdata;
                        base_ram_data_oe = 1'b1;
                    end else begin
                        base_ram_be_n = 4'h0;
                        base_ram_oe_n = 1'b0;
                    end
                end else begin
                    ext_ram_ce_n = 1'b0;
                    ext_ram_addr = r_ram_addr;
                    if (r_we) begin
                        ext_ram_be_n    = ~r_be;
                        ext_ram_we_n    = (r_cnt == '0);
                        ext_ram_wdata   = r_wdata;
                        ext_ram_data_oe = 1'b1;
                    end else begin
                        ext_ram_be_n = 4'h0;
                        ext_ram_oe_n = 1'b0;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                bus.ack     = c_ACK_ONE << r_idx;
                bus.ack_err = r_err;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_arbiter
//  Description : Directed bench for sram_arbiter: three configurations
//                (2 ports fixed, 2 ports round-robin, 3 ports / 4 waits).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  ack;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct packed {
        logic [19:0] addr;
        logic [3:0]  be_n;
        logic        ce_n;
        logic        oe_n;
        logic        we_n;
        logic [31:0] wdata;
        logic        doe;
    } bank_t;

    localparam bank_t C_IDLE = '{addr: 20'h0, be_n: 4'hF, ce_n: 1'b1, oe_n: 1'b1,
                                 we_n: 1'b1, wdata: 32'h0, doe: 1'b0};

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t ea, eb, ec;

    // ---------------- DUT A: 2 ports, 2 waits, fixed priority --------------
    sram_arbiter_if #(.NUM_PORTS(2)) if_a();
    logic [19:0] a_base_addr, a_ext_addr;
    logic [3:0]  a_base_be_n, a_ext_be_n;
    logic        a_base_ce_n, a_base_oe_n, a_base_we_n, a_base_doe;
    logic        a_ext_ce_n, a_ext_oe_n, a_ext_we_n, a_ext_doe;
    logic [31:0] a_base_wdata, a_ext_wdata, a_base_rdata, a_ext_rdata;
    bank_t       a_base, a_ext;
    assign a_base = {a_base_addr, a_base_be_n, a_base_ce_n, a_base_oe_n, a_base_we_n, a_base_wdata, a_base_doe};
    assign a_ext  = {a_ext_addr, a_ext_be_n, a_ext_ce_n, a_ext_oe_n, a_ext_we_n, a_ext_wdata, a_ext_doe};

    sram_arbiter #(.NUM_PORTS(2), .WAIT_CYCLES(2), .RR_MODE(0)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a),
        .base_ram_addr(a_base_addr), .base_ram_be_n(a_base_be_n), .base_ram_ce_n(a_base_ce_n),
        .base_ram_oe_n(a_base_oe_n), .base_ram_we_n(a_base_we_n), .base_ram_wdata(a_base_wdata),
        .base_ram_data_oe(a_base_doe), .base_ram_rdata(a_base_rdata),
        .ext_ram_addr(a_ext_addr), .ext_ram_be_n(a_ext_be_n), .ext_ram_ce_n(a_ext_ce_n),
        .ext_ram_oe_n(a_ext_oe_n), .ext_ram_we_n(a_ext_we_n), .ext_ram_wdata(a_ext_wdata),
        .ext_ram_data_oe(a_ext_doe), .ext_ram_rdata(a_ext_rdata)
    );

    // ---------------- DUT B: 2 ports, 2 waits, round-robin -----------------
    sram_arbiter_if #(.NUM_PORTS(2)) if_b();
    logic [19:0] b_base_addr, b_ext_addr;
    logic [3:0]  b_base_be_n, b_ext_be_n;
    logic        b_base_ce_n, b_base_oe_n, b_base_we_n, b_base_doe;
    logic        b_ext_ce_n, b_ext_oe_n, b_ext_we_n, b_ext_doe;
    logic [31:0] b_base_wdata, b_ext_wdata, b_base_rdata, b_ext_rdata;

    sram_arbiter #(.NUM_PORTS(2), .WAIT_CYCLES(2), .RR_MODE(1)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b),
        .base_ram_addr(b_base_addr), .base_ram_be_n(b_base_be_n), .base_ram_ce_n(b_base_ce_n),
        .base_ram_oe_n(b_base_oe_n), .base_ram_we_n(b_base_we_n), .base_ram_wdata(b_base_wdata),
        .base_ram_data_oe(b_base_doe), .base_ram_rdata(b_base_rdata),
        .ext_ram_addr(b_ext_addr), .ext_ram_be_n(b_ext_be_n), .ext_ram_ce_n(b_ext_ce_n),
        .ext_ram_oe_n(b_ext_oe_n), .ext_ram_we_n(b_ext_we_n), .ext_ram_wdata(b_ext_wdata),
        .ext_ram_data_oe(b_ext_doe), .ext_ram_rdata(b_ext_rdata)
    );

    // ---------------- DUT C: 3 ports, 4 waits, fixed priority --------------
    sram_arbiter_if #(.NUM_PORTS(3)) if_c();
    logic [19:0] c_base_addr, c_ext_addr;
    logic [3:0]  c_base_be_n, c_ext_be_n;
    logic        c_base_ce_n, c_base_oe_n, c_base_we_n, c_base_doe;
    logic        c_ext_ce_n, c_ext_oe_n, c_ext_we_n, c_ext_doe;
    logic [31:0] c_base_wdata, c_ext_wdata, c_base_rdata, c_ext_rdata;

    sram_arbiter #(.NUM_PORTS(3), .WAIT_CYCLES(4), .RR_MODE(0)) dut_c (
        .clk(clk), .reset(reset), .bus(if_c),
        .base_ram_addr(c_base_addr), .base_ram_be_n(c_base_be_n), .base_ram_ce_n(c_base_ce_n),
        .base_ram_oe_n(c_base_oe_n), .base_ram_we_n(c_base_we_n), .base_ram_wdata(c_base_wdata),
        .base_ram_data_oe(c_base_doe), .base_ram_rdata(c_base_rdata),
        .ext_ram_addr(c_ext_addr), .ext_ram_be_n(c_ext_be_n), .ext_ram_ce_n(c_ext_ce_n),
        .ext_ram_oe_n(c_ext_oe_n), .ext_ram_we_n(c_ext_we_n), .ext_ram_wdata(c_ext_wdata),
        .ext_ram_data_oe(c_ext_doe), .ext_ram_rdata(c_ext_rdata)
    );

    // One comparison: counts, and reports on mismatch.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected strobes of the selected bank during an access cycle.
    function automatic bank_t exp_sel(input logic we, input logic [3:0] be,
                                      input logic [19:0] ra, input logic [31:0] wd,
                                      input logic last);
        bank_t b;
        b      = C_IDLE;
        b.addr = ra;
        b.ce_n = 1'b0;
        if (we) begin
            b.be_n  = ~be;
            b.we_n  = last;
            b.wdata = wd;
            b.doe   = 1'b1;
        end else begin
            b.be_n = 4'h0;
            b.oe_n = 1'b0;
        end
        return b;
    endfunction

    // Scoreboard monitors: every completion pops the oldest expectation.
    always @(negedge clk) begin
        if (if_a.ack !== 2'b00 || if_a.ack_err !== 1'b0) begin
            if (q_a.size() == 0) begin
                chk("a_spurious_ack", {if_a.ack_err, if_a.ack}, 64'h0);
            end else begin
                ea = q_a.pop_front();
                chk("a_ack_port", if_a.ack, ea.ack);
                chk("a_ack_err", if_a.ack_err, ea.err);
                chk("a_rdata", if_a.rdata, ea.rdata);
            end
        end
    end

    always @(negedge clk) begin
        if (if_b.ack !== 2'b00 || if_b.ack_err !== 1'b0) begin
            if (q_b.size() == 0) begin
                chk("b_spurious_ack", {if_b.ack_err, if_b.ack}, 64'h0);
            end else begin
                eb = q_b.pop_front();
                chk("b_ack_port", if_b.ack, eb.ack);
                chk("b_ack_err", if_b.ack_err, eb.err);
                chk("b_rdata", if_b.rdata, eb.rdata);
            end
        end
    end

    always @(negedge clk) begin
        if (if_c.ack !== 3'b000 || if_c.ack_err !== 1'b0) begin
            if (q_c.size() == 0) begin
                chk("c_spurious_ack", {if_c.ack_err, if_c.ack}, 64'h0);
            end else begin
                ec = q_c.pop_front();
                chk("c_ack_port", if_c.ack, ec.ack);
                chk("c_ack_err", if_c.ack_err, ec.err);
                chk("c_rdata", if_c.rdata, ec.rdata);
            end
        end
    end

    // One transaction on DUT A with cycle-by-cycle strobe checks.
    task automatic txn_a(input int port, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input bit drop_early);
        logic        mapped;
        logic        bank;
        logic [19:0] ra;
        exp_t        e;
        bank_t       exp_b, obs;
        mapped = (addr[31:23] == 9'h100);
        bank   = addr[22];
        ra     = addr[21:2];
        @(posedge clk); #1;
        chk("a_idle_base", a_base, C_IDLE);
        chk("a_idle_ext", a_ext, C_IDLE);
        if_a.req[port]            = 1'b1;
        if_a.we[port]             = we;
        if_a.be[4*port +: 4]      = be;
        if_a.addr[32*port +: 32]  = addr;
        if_a.wdata[32*port +: 32] = wd;
        a_base_rdata = bank ? ~rd : rd;
        a_ext_rdata  = bank ? rd : ~rd;
        e.ack   = 8'(1 << port);
        e.err   = !mapped;
        e.rdata = (mapped && !we) ? rd : 32'h0;
        q_a.push_back(e);
        if (mapped) begin
            for (int c = 1; c <= 2; c++) begin
                @(posedge clk); #1;
                if (drop_early && c == 1) begin
                    if_a.req[port]           = 1'b0;
                    if_a.we[port]            = ~we;
                    if_a.addr[32*port +: 32] = 32'h8000_0FF0;
                    if_a.be[4*port +: 4]     = ~be;
                end
                exp_b = exp_sel(we, be, ra, wd, c == 2);
                obs   = bank ? a_ext : a_base;
                if (!we) obs.wdata = 32'h0;
                chk("a_sel_bank", obs, exp_b);
                chk("a_other_bank", bank ? a_base : a_ext, C_IDLE);
                chk("a_no_early_ack", if_a.ack, 2'b00);
            end
        end
        @(posedge clk); #1;
        chk("a_ack_latency", if_a.ack, 64'(1 << port));
        chk("a_done_base", a_base, C_IDLE);
        chk("a_done_ext", a_ext, C_IDLE);
        if_a.req[port] = 1'b0;
        @(posedge clk); #1;
        chk("a_ack_single", if_a.ack, 2'b00);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int lat;
        int low;
        bit got;
        reset = 1'b1;
        if_a.req = '0; if_a.we = '0; if_a.be = '0; if_a.addr = '0; if_a.wdata = '0;
        if_b.req = '0; if_b.we = '0; if_b.be = '0; if_b.addr = '0; if_b.wdata = '0;
        if_c.req = '0; if_c.we = '0; if_c.be = '0; if_c.addr = '0; if_c.wdata = '0;
        a_base_rdata = '0; a_ext_rdata = '0;
        b_base_rdata = '0; b_ext_rdata = '0;
        c_base_rdata = '0; c_ext_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", if_a.ack, 2'b00);
        chk("rst_ack_err", if_a.ack_err, 1'b0);
        chk("rst_rdata", if_a.rdata, 32'h0);
        chk("rst_base", a_base, C_IDLE);
        chk("rst_ext", a_ext, C_IDLE);
        reset = 1'b0;

        // Basic read, write, unmapped and early-drop transactions.
        txn_a(1, 1'b0, 4'hF,    32'h8000_0010, 32'h0,         32'h1234_5678, 1'b0);
        txn_a(0, 1'b1, 4'b0011, 32'h8040_0008, 32'hAABB_CCDD, 32'h55AA_55AA, 1'b0);
        txn_a(0, 1'b0, 4'hF,    32'h9000_0000, 32'h0,         32'h7777_7777, 1'b0);
        txn_a(1, 1'b0, 4'hF,    32'h8080_0000, 32'h0,         32'h6666_6666, 1'b0);
        txn_a(1, 1'b1, 4'b1010, 32'h8000_1000, 32'h0102_0304, 32'h0,         1'b1);
        txn_a(0, 1'b0, 4'hF,    32'h807F_FFFC, 32'h0,         32'h89AB_CDEF, 1'b1);

        // Reset in the second access cycle of a write aborts it silently.
        @(posedge clk); #1;
        if_a.req[0] = 1'b1; if_a.we[0] = 1'b1; if_a.be[3:0] = 4'hF;
        if_a.addr[31:0] = 32'h8000_0020; if_a.wdata[31:0] = 32'hFEED_FACE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_doe_before", a_base_doe, 1'b1);
        reset = 1'b1;
        if_a.req = '0;
        @(posedge clk); #1;
        chk("rst_mid_base", a_base, C_IDLE);
        chk("rst_mid_ext", a_ext, C_IDLE);
        chk("rst_mid_ack", if_a.ack, 2'b00);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ack_after", if_a.ack, 2'b00);
        txn_a(1, 1'b0, 4'hF, 32'h8000_0024, 32'h0, 32'h3C3C_A5A5, 1'b0);

        // Fixed priority: port 0 monopolises while it requests.
        @(posedge clk); #1;
        a_base_rdata = 32'h1111_1111;
        a_ext_rdata  = 32'h2222_2222;
        if_a.we = 2'b00; if_a.be = 8'hFF;
        if_a.addr = {32'h8040_0040, 32'h8000_0040};
        if_a.req = 2'b11;
        for (int k = 0; k < 3; k++) q_a.push_back('{ack: 8'h01, err: 1'b0, rdata: 32'h1111_1111});
        q_a.push_back('{ack: 8'h02, err: 1'b0, rdata: 32'h2222_2222});
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(posedge clk); #1;
            if (if_a.ack != 2'b00) begin
                n++;
                if (n == 3) if_a.req[0] = 1'b0;
                if (n == 4) if_a.req[1] = 1'b0;
            end
        end
        chk("a_fixed_ack_count", n, 4);
        if_a.req = '0;

        // Round-robin: strictly alternating 0,1,0,1.
        @(posedge clk); #1;
        b_base_rdata = 32'h0B0B_0B0B;
        b_ext_rdata  = 32'h0E0E_0E0E;
        if_b.we = 2'b00; if_b.be = 8'hFF;
        if_b.addr = {32'h8000_0004, 32'h8000_0000};
        if_b.req = 2'b11;
        for (int k = 0; k < 4; k++) q_b.push_back('{ack: (k % 2 == 0) ? 8'h01 : 8'h02, err: 1'b0, rdata: 32'h0B0B_0B0B});
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(posedge clk); #1;
            if (if_b.ack != 2'b00) begin
                n++;
                if (n == 4) if_b.req = 2'b00;
            end
        end
        chk("b_rr_ack_count", n, 4);
        if_b.req = '0;

        // Three ports, four wait states: port 2 read from ExtRAM.
        @(posedge clk); #1;
        c_ext_rdata  = 32'hCAFE_F00D;
        c_base_rdata = 32'h0BAD_BEEF;
        if_c.we[2] = 1'b0; if_c.be[11:8] = 4'hF;
        if_c.addr[95:64] = 32'h8040_0100;
        if_c.req[2] = 1'b1;
        q_c.push_back('{ack: 8'h04, err: 1'b0, rdata: 32'hCAFE_F00D});
        lat = 0; low = 0; got = 1'b0;
        for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
            @(posedge clk); #1;
            if (c_ext_ce_n == 1'b0) begin
                low++;
                chk("c_ext_addr", c_ext_addr, 20'h00040);
                chk("c_base_ce_n", c_base_ce_n, 1'b1);
            end
            if (if_c.ack != 3'b000) begin
                got = 1'b1;
                lat = cyc;
            end
        end
        chk("c_ack_latency", lat, 5);
        chk("c_access_cycles", low, 4);
        if_c.req = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("a_scoreboard_empty", q_a.size(), 0);
        chk("b_scoreboard_empty", q_b.size(), 0);
        chk("c_scoreboard_empty", q_c.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
